rob_complete_arbiter: RTL and testbench

ROB_COMPLETE_ARBITER -- requirements
Module: rob_complete_arbiter

---
 rtl/rob_complete_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_rob_complete_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rob_complete_arbiter.sv
// rob_complete_arbiter
//   Collects completion reports from three execution units (0=ALU, 1=MULT,
//   2=LSQ) into one-entry holding slots and forwards at most one per cycle
//   to the ROB as a registered one-cycle strobe. Redirecting completions
//   (changeFlow=1) beat plain ones; ties rotate round-robin. After a
//   redirect is issued the block stalls until the ROB rollback (recover)
//   has been seen and released, discarding everything held meanwhile.
//
// Ports
//   clk, rst                  clock, async active-low reset
//   req_valid/req_ready [3]   per-requester handshake
//   req_rob_num  [3*ROB_W]    per-requester ROB index
//   req_jb_addr  [3*ADDR_W]   per-requester redirect address
//   req_changeFlow [3]        per-requester redirect flag
//   recover                   ROB rollback in progress
//   complete                  one-cycle completion strobe
//   rob_number/jb_addr/changeFlow  completing entry
//   state_out                 RUN=0, WAIT_RB=1, FLUSH=2

// One holding slot. Load beats clear so a slot granted and refilled on the
// same edge keeps the new entry; flush beats both.
module rob_cmp_slot #(
    parameter int ROB_W  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              clear,
    input  logic [ROB_W-1:0]  in_rob,
    input  logic [ADDR_W-1:0] in_jb,
    input  logic              in_cf,
    output logic              full,
    output logic [ROB_W-1:0]  rob,
    output logic [ADDR_W-1:0] jb,
    output logic              cf
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            rob  <= '0;
            jb   <= '0;
            cf   <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            rob  <= in_rob;
            jb   <= in_jb;
            cf   <= in_cf;
        end else if (clear) begin
            full <= 1'b0;
        end
    end
endmodule

module rob_complete_arbiter #(
    parameter int ROB_W  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req_valid,
    input  logic [3*ROB_W-1:0]  req_rob_num,
    input  logic [3*ADDR_W-1:0] req_jb_addr,
    input  logic [2:0]          req_changeFlow,
    output logic [2:0]          req_ready,
    input  logic                recover,
    output logic                complete,
    output logic [ROB_W-1:0]    rob_number,
    output logic [ADDR_W-1:0]   jb_addr,
    output logic                changeFlow,
    output logic [1:0]          state_out
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_RB = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0]             full, cf, grant, hi, load;
    logic [3:0]             cand;
    logic [2:0][ROB_W-1:0]  s_rob;
    logic [2:0][ADDR_W-1:0] s_jb;
    logic [1:0]             rr_ptr, ord0, ord1, ord2, gidx;
    logic                   gvalid, g_cf;
    logic [ROB_W-1:0]       g_rob;
    logic [ADDR_W-1:0]      g_jb;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // ---------------- holding slots ----------------
    for (genvar i = 0; i < 3; i++) begin : g_slot
        assign load[i] = req_valid[i] & req_ready[i];
        rob_cmp_slot #(.ROB_W(ROB_W), .ADDR_W(ADDR_W)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .flush  (state == FLUSH),
            .load   (load[i]),
            .clear  (grant[i]),
            .in_rob (req_rob_num[i*ROB_W +: ROB_W]),
            .in_jb  (req_jb_addr[i*ADDR_W +: ADDR_W]),
            .in_cf  (req_changeFlow[i]),
            .full   (full[i]),
            .rob    (s_rob[i]),
            .jb     (s_jb[i]),
            .cf     (cf[i])
        );
    end

    // ---------------- grant selection ----------------
    // Redirecting slots form the candidate set when any exist; the search
    // then walks indices starting at rr_ptr. recover suppresses any grant.
    always_comb begin
        hi     = full & cf;
        cand   = {1'b0, (|hi) ? hi : full};
        ord0   = rr_ptr;
        ord1   = nxt(ord0);
        ord2   = nxt(ord1);
        gvalid = 1'b0;
        gidx   = 2'd0;
        if (state == RUN && !recover) begin
            if (cand[ord0]) begin
                gvalid = 1'b1;
                gidx   = ord0;
            end else if (cand[ord1]) begin
                gvalid = 1'b1;
                gidx   = ord1;
            end else if (cand[ord2]) begin
                gvalid = 1'b1;
                gidx   = ord2;
            end
        end
        grant = gvalid ? (3'b001 << gidx) : 3'b000;
        g_rob = '0;
        g_jb  = '0;
        g_cf  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                g_rob = s_rob[i];
                g_jb  = s_jb[i];
                g_cf  = cf[i];
            end
        end
    end

    // ---------------- completion output register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            complete   <= 1'b0;
            rob_number <= '0;
            jb_addr    <= '0;
            changeFlow <= 1'b0;
            rr_ptr     <= 2'd0;
        end else if (gvalid) begin
            complete   <= 1'b1;
            rob_number <= g_rob;
            jb_addr    <= g_jb;
            changeFlow <= g_cf;
            rr_ptr     <= nxt(gidx);
        end else begin
            complete   <= 1'b0;
            changeFlow <= 1'b0;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (recover)              state_nxt = FLUSH;
                else if (gvalid && g_cf)  state_nxt = WAIT_RB;
            end
            WAIT_RB: if (recover)  state_nxt = FLUSH;
            FLUSH:   if (!recover) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // A slot accepts when empty or leaving this cycle; rst gates ready low
    // while reset is held.
    always_comb begin
        state_out = state;
        req_ready = 3'b000;
        if (rst && state == RUN) req_ready = ~full | grant;
    end
endmodule

// File: tb/tb_rob_complete_arbiter.sv
module tb_rob_complete_arbiter;
    localparam int ROB_W  = 4;
    localparam int ADDR_W = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [2:0]          req_valid = '0;
    logic [3*ROB_W-1:0]  req_rob_num = '0;
    logic [3*ADDR_W-1:0] req_jb_addr = '0;
    logic [2:0]          req_changeFlow = '0;
    logic [2:0]          req_ready;
    logic                recover = 1'b0;
    logic                complete;
    logic [ROB_W-1:0]    rob_number;
    logic [ADDR_W-1:0]   jb_addr;
    logic                changeFlow;
    logic [1:0]          state_out;

    rob_complete_arbiter #(.ROB_W(ROB_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rob_num(req_rob_num),
        .req_jb_addr(req_jb_addr), .req_changeFlow(req_changeFlow),
        .req_ready(req_ready), .recover(recover),
        .complete(complete), .rob_number(rob_number), .jb_addr(jb_addr),
        .changeFlow(changeFlow), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ROB_W-1:0]  rob;
        logic [ADDR_W-1:0] jb;
        logic              cf;
        int                cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor: every complete strobe must match the oldest expectation,
    // including the cycle on which it was predicted to appear.
    always @(negedge clk) begin
        if (complete === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_complete: got rob %0h expected no complete", rob_number);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cmp_rob", 64'(rob_number), 64'(e.rob));
                chk("cmp_jb",  64'(jb_addr),    64'(e.jb));
                chk("cmp_cf",  64'(changeFlow), 64'(e.cf));
                chk("cmp_cyc", 64'(cyc),        64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push(input logic [ROB_W-1:0] r, input logic [ADDR_W-1:0] j,
                        input logic c, input int lat);
        exp_t e;
        e.rob = r; e.jb = j; e.cf = c; e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [2:0] v, input logic [3*ROB_W-1:0] r,
                         input logic [3*ADDR_W-1:0] j, input logic [2:0] c);
        req_valid = v; req_rob_num = r; req_jb_addr = j; req_changeFlow = c;
    endtask

    task automatic idle();
        drive(3'b000, '0, '0, 3'b000);
    endtask

    initial begin
        // reset state
        repeat (2) neg();
        chk("rst_complete",   64'(complete),   64'd0);
        chk("rst_ready",      64'(req_ready),  64'd0);
        chk("rst_state",      64'(state_out),  64'd0);
        chk("rst_rob_number", 64'(rob_number), 64'd0);
        chk("rst_jb_addr",    64'(jb_addr),    64'd0);
        chk("rst_changeFlow", 64'(changeFlow), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        neg();
        chk("ready_after_rst", 64'(req_ready), 64'b111);

        // three simultaneous requests, rr_ptr=0 -> 2,3,4
        tick();
        drive(3'b111, {4'd4, 4'd3, 4'd2}, '0, 3'b000);
        push(4'd2, 32'h0, 1'b0, 2);
        push(4'd3, 32'h0, 1'b0, 3);
        push(4'd4, 32'h0, 1'b0, 4);
        tick(); idle();
        neg(); chk("simul_ready1", 64'(req_ready), 64'b001);
        tick(); neg(); chk("simul_ready2", 64'(req_ready), 64'b011);
        tick(); neg(); chk("simul_ready3", 64'(req_ready), 64'b111);
        tick(); tick();

        // single ALU request
        drive(3'b001, {4'd0, 4'd0, 4'd1}, '0, 3'b000);
        push(4'd1, 32'h0, 1'b0, 2);
        tick(); idle();
        neg(); chk("single_ready", 64'(req_ready), 64'b111);
        tick(); tick();

        // back-to-back streaming on ALU
        for (int i = 0; i < 8; i++) begin
            drive(3'b001, {4'd0, 4'd0, 4'(i)}, '0, 3'b000);
            push(4'(i), 32'h0, 1'b0, 2);
            tick();
        end
        idle();
        tick(); tick(); tick();

        // priority: LSQ redirect beats MULT; MULT then held in WAIT_RB
        drive(3'b110, {4'd3, 4'd5, 4'd0}, {32'h10, 32'h0, 32'h0}, 3'b100);
        push(4'd3, 32'h10, 1'b1, 2);
        tick(); idle();
        tick();
        neg(); chk("prio_state", 64'(state_out), 64'd1);
        chk("prio_ready", 64'(req_ready), 64'b000);
        tick(); tick();
        neg(); chk("wait_state_hold", 64'(state_out), 64'd1);

        // rollback: recover for 3 cycles
        tick();
        recover = 1'b1;
        tick();
        neg(); chk("flush_state", 64'(state_out), 64'd2);
        chk("flush_ready", 64'(req_ready), 64'b000);
        tick(); tick();
        recover = 1'b0;
        tick();
        neg(); chk("rb_run_state", 64'(state_out), 64'd0);
        chk("rb_run_ready", 64'(req_ready), 64'b111);
        chk("hold_jb_addr", 64'(jb_addr), 64'h10);
        chk("hold_rob_number", 64'(rob_number), 64'd3);
        chk("idle_changeFlow", 64'(changeFlow), 64'd0);
        tick(); tick();

        // recover wins over a pending grant
        drive(3'b001, {4'd0, 4'd0, 4'd9}, '0, 3'b000);
        tick(); idle();
        recover = 1'b1;
        tick();
        neg(); chk("rw_state", 64'(state_out), 64'd2);
        chk("rw_complete", 64'(complete), 64'd0);
        tick();
        recover = 1'b0;
        tick();
        neg(); chk("rw_run_state", 64'(state_out), 64'd0);
        chk("rw_run_ready", 64'(req_ready), 64'b111);
        tick(); tick();

        // async reset mid-stream
        drive(3'b001, {4'd0, 4'd0, 4'd10}, '0, 3'b000);
        push(4'd10, 32'h0, 1'b0, 2);
        tick();
        drive(3'b001, {4'd0, 4'd0, 4'd11}, '0, 3'b000);
        tick();
        drive(3'b001, {4'd0, 4'd0, 4'd12}, '0, 3'b000);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_complete",   64'(complete),   64'd0);
        chk("arst_ready",      64'(req_ready),  64'd0);
        chk("arst_rob_number", 64'(rob_number), 64'd0);
        chk("arst_state",      64'(state_out),  64'd0);
        idle();
        tick(); tick();
        @(posedge clk); #1 rst = 1'b1;
        tick(); tick(); tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
